// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its mult/div busy timer.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Forwarding select encodings (D and E operand muxes)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    // Mult/div operation in E; 2'b11 is reserved and behaves as none
    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // Tuse value meaning "operand not read"; never below any Tnew, so never stalls
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Pick the freshest ready producer for one source operand; M wins over W, $0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] a3_m,
        input logic       rw_m,
        input logic [1:0] tnew_m,
        input logic [4:0] a3_w,
        input logic       rw_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (rw_m && (a3_m == src) && (tnew_m == 2'd0)) begin
                sel = FWD_M;
            end else if (rw_w && (a3_w == src)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: loads the op's cycle count when it issues from E, then counts down.
// Latency: md_busy rises the cycle after issue and stays high exactly MULT_CYC / DIV_CYC cycles.
// Backpressure: none; a new issue while counting simply reloads (last issue wins).
module hazard_ctrl_md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] md_op_E,
    output logic       md_busy
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    logic [CW-1:0] count;

    // Load on issue, otherwise run down to zero; reset abandons any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (md_op_E == MD_MULT) begin
            count <= CW'(MULT_CYC);
        end else if (md_op_E == MD_DIV) begin
            count <= CW'(DIV_CYC);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign md_busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/forward controller: Tuse/Tnew data stalls, HI/LO busy stalls, forward selects.
// Latency: stall/enable/forward outputs are combinational; md_busy and stall_cnt are registered.
// Backpressure: a stall freezes PC and F_D and inserts a bubble into D_E.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       A1_D,
    input  logic [4:0]       A2_D,
    input  logic [1:0]       Tuse_rs,
    input  logic [1:0]       Tuse_rt,
    input  logic             md_use_D,
    input  logic [4:0]       A1_E,
    input  logic [4:0]       A2_E,
    input  logic [4:0]       A3_E,
    input  logic [4:0]       A3_M,
    input  logic [4:0]       A3_W,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic [1:0]       Tnew_E,
    input  logic [1:0]       Tnew_M,
    input  logic [1:0]       md_op_E,
    output logic             en_PC,
    output logic             en_FD,
    output logic             clr_DE,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    hazard_ctrl_md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .md_op_E (md_op_E),
        .md_busy (md_busy)
    );

    // Stall when a D operand is needed before an in-flight producer in E or M can supply it
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (A1_D != 5'd0) begin
            stall_rs = (RegWrite_E && (A3_E == A1_D) && (Tuse_rs < Tnew_E)) ||
                       (RegWrite_M && (A3_M == A1_D) && (Tuse_rs < Tnew_M));
        end
        if (A2_D != 5'd0) begin
            stall_rt = (RegWrite_E && (A3_E == A2_D) && (Tuse_rt < Tnew_E)) ||
                       (RegWrite_M && (A3_M == A2_D) && (Tuse_rt < Tnew_M));
        end
        stall_md = md_use_D && (md_busy || (md_op_E == MD_MULT) || (md_op_E == MD_DIV));
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Freeze fetch/decode and bubble execute while stalled
    always_comb begin
        en_PC  = !stall;
        en_FD  = !stall;
        clr_DE = stall;
    end

    // Operand forward selects; E results are never ready for D, so only M and W are sources
    always_comb begin
        fwd_rs_D = fwd_sel(A1_D, A3_M, RegWrite_M, Tnew_M, A3_W, RegWrite_W);
        fwd_rt_D = fwd_sel(A2_D, A3_M, RegWrite_M, Tnew_M, A3_W, RegWrite_W);
        fwd_rs_E = fwd_sel(A1_E, A3_M, RegWrite_M, Tnew_M, A3_W, RegWrite_W);
        fwd_rt_E = fwd_sel(A2_E, A3_M, RegWrite_M, Tnew_M, A3_W, RegWrite_W);
    end

    // Count every stalled cycle since reset; wraps naturally at the counter width
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios followed by random input cycles.
// Latency: expectations for a cycle are queued when its inputs are applied, checked mid-cycle.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic       reset;
        logic [4:0] a1_d, a2_d, a1_e, a2_e, a3_e, a3_m, a3_w;
        logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m, md_op_e;
        logic       md_use_d, rw_e, rw_m, rw_w;
    } in_t;

    typedef struct {
        logic        en_pc, en_fd, clr_de, md_busy;
        logic [1:0]  f_rs_d, f_rt_d, f_rs_e, f_rt_e;
        logic [31:0] stall_cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  A1_D, A2_D, A1_E, A2_E, A3_E, A3_M, A3_W;
    logic [1:0]  Tuse_rs, Tuse_rt, Tnew_E, Tnew_M, md_op_E;
    logic        md_use_D, RegWrite_E, RegWrite_M, RegWrite_W;
    logic        en_PC, en_FD, clr_DE, md_busy;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [31:0] stall_cnt;

    hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .md_use_D(md_use_D),
        .A1_E(A1_E), .A2_E(A2_E), .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .md_op_E(md_op_E),
        .en_PC(en_PC), .en_FD(en_FD), .clr_DE(clr_DE),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state: cycle index, last cycle the unit is busy, stall total
    int          cyc = 0;
    int          busy_last = -1;
    logic [31:0] m_stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // A producer (E or M) blocks an operand read that is needed before the value exists
    function automatic bit model_data_stall(input in_t v);
        logic [4:0] src[2];
        int         tuse[2];
        logic [4:0] dst[2];
        bit         wr[2];
        int         tnew[2];
        bit         s;
        src  = '{v.a1_d, v.a2_d};
        tuse = '{int'(v.tuse_rs), int'(v.tuse_rt)};
        dst  = '{v.a3_e, v.a3_m};
        wr   = '{v.rw_e, v.rw_m};
        tnew = '{int'(v.tnew_e), int'(v.tnew_m)};
        s = 0;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (src[i] != 0 && tuse[i] != 3 && wr[p] && dst[p] == src[i] && tuse[i] < tnew[p])
                    s = 1;
        return s;
    endfunction

    // Ready M result beats W; W is always ready; register 0 is hardwired
    function automatic logic [1:0] model_fwd(input logic [4:0] src, input in_t v);
        if (src == 0) return 2'd0;
        if (v.rw_m && v.a3_m == src && v.tnew_m == 0) return 2'd1;
        if (v.rw_w && v.a3_w == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '{reset: 1'b0, a1_d: 5'd0, a2_d: 5'd0, a1_e: 5'd0, a2_e: 5'd0,
              a3_e: 5'd0, a3_m: 5'd0, a3_w: 5'd0,
              tuse_rs: 2'd3, tuse_rt: 2'd3, tnew_e: 2'd0, tnew_m: 2'd0, md_op_e: 2'd0,
              md_use_d: 1'b0, rw_e: 1'b0, rw_m: 1'b0, rw_w: 1'b0};
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        int  r;
        v          = idle();
        v.reset    = ($urandom_range(0, 63) == 0);
        v.a1_d     = 5'($urandom_range(0, 3));
        v.a2_d     = 5'($urandom_range(0, 3));
        v.a1_e     = 5'($urandom_range(0, 3));
        v.a2_e     = 5'($urandom_range(0, 3));
        v.a3_e     = 5'($urandom_range(0, 3));
        v.a3_m     = 5'($urandom_range(0, 3));
        v.a3_w     = 5'($urandom_range(0, 3));
        v.tuse_rs  = 2'($urandom_range(0, 3));
        v.tuse_rt  = 2'($urandom_range(0, 3));
        v.tnew_e   = 2'($urandom_range(0, 3));
        v.tnew_m   = 2'($urandom_range(0, 3));
        v.rw_e     = 1'($urandom_range(0, 1));
        v.rw_m     = 1'($urandom_range(0, 1));
        v.rw_w     = 1'($urandom_range(0, 1));
        v.md_use_d = ($urandom_range(0, 3) == 0);
        r          = int'($urandom_range(0, 15));
        v.md_op_e  = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : (r == 2) ? 2'd3 : 2'd0;
        return v;
    endfunction

    // Apply one cycle of inputs, queue what the outputs must show, advance the model
    task automatic step(input in_t v);
        exp_t e;
        bit   busy;
        bit   stall;
        reset = v.reset;  A1_D = v.a1_d;  A2_D = v.a2_d;  A1_E = v.a1_e;  A2_E = v.a2_e;
        A3_E = v.a3_e;  A3_M = v.a3_m;  A3_W = v.a3_w;  Tuse_rs = v.tuse_rs;  Tuse_rt = v.tuse_rt;
        Tnew_E = v.tnew_e;  Tnew_M = v.tnew_m;  md_op_E = v.md_op_e;  md_use_D = v.md_use_d;
        RegWrite_E = v.rw_e;  RegWrite_M = v.rw_m;  RegWrite_W = v.rw_w;

        busy  = (cyc <= busy_last);
        stall = model_data_stall(v) ||
                (v.md_use_d && (busy || v.md_op_e == 2'd1 || v.md_op_e == 2'd2));
        e.en_pc     = !stall;
        e.en_fd     = !stall;
        e.clr_de    = stall;
        e.md_busy   = busy;
        e.f_rs_d    = model_fwd(v.a1_d, v);
        e.f_rt_d    = model_fwd(v.a2_d, v);
        e.f_rs_e    = model_fwd(v.a1_e, v);
        e.f_rt_e    = model_fwd(v.a2_e, v);
        e.stall_cnt = m_stall_cnt;
        sb.push_back(e);

        if (v.reset) begin
            busy_last   = cyc;
            m_stall_cnt = 0;
        end else begin
            if (v.md_op_e == 2'd1) busy_last = cyc + MULT_N;
            else if (v.md_op_e == 2'd2) busy_last = cyc + DIV_N;
            if (stall) m_stall_cnt = m_stall_cnt + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest queued expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("en_PC",     32'(en_PC),    32'(e.en_pc));
            check("en_FD",     32'(en_FD),    32'(e.en_fd));
            check("clr_DE",    32'(clr_DE),   32'(e.clr_de));
            check("fwd_rs_D",  32'(fwd_rs_D), 32'(e.f_rs_d));
            check("fwd_rt_D",  32'(fwd_rt_D), 32'(e.f_rt_d));
            check("fwd_rs_E",  32'(fwd_rs_E), 32'(e.f_rs_e));
            check("fwd_rt_E",  32'(fwd_rt_E), 32'(e.f_rt_e));
            check("md_busy",   32'(md_busy),  32'(e.md_busy));
            check("stall_cnt", stall_cnt,     e.stall_cnt);
        end
    end

    initial begin
        in_t v;
        v = idle();
        v.reset = 1'b1;
        reset = 1'b1;  A1_D = 0;  A2_D = 0;  A1_E = 0;  A2_E = 0;  A3_E = 0;  A3_M = 0;  A3_W = 0;
        Tuse_rs = 2'd3;  Tuse_rt = 2'd3;  Tnew_E = 0;  Tnew_M = 0;  md_op_E = 0;  md_use_D = 0;
        RegWrite_E = 0;  RegWrite_M = 0;  RegWrite_W = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state is visible while reset is still held
        step(v);

        // lw $1 in E, beq in D reading $1 at Tuse 0
        v = idle();  v.a1_d = 1;  v.tuse_rs = 0;  v.rw_e = 1;  v.a3_e = 1;  v.tnew_e = 2;
        step(v);
        // load moves to M with one cycle left
        v = idle();  v.a1_d = 1;  v.tuse_rs = 0;  v.rw_m = 1;  v.a3_m = 1;  v.tnew_m = 1;
        step(v);
        // load reaches W: no stall, forward from W, two stalls counted
        v = idle();  v.a1_d = 1;  v.tuse_rs = 0;  v.rw_w = 1;  v.a3_w = 1;
        step(v);

        // addu $3 in M and in W: M wins for rt
        v = idle();  v.a2_d = 3;  v.tuse_rt = 1;  v.rw_m = 1;  v.a3_m = 3;  v.tnew_m = 0;
        v.rw_w = 1;  v.a3_w = 3;  v.a1_e = 3;  v.a2_e = 3;
        step(v);

        // div issues while mflo waits in D: stall through issue plus ten busy cycles
        v = idle();  v.md_use_d = 1;  v.md_op_e = 2'd2;
        step(v);
        v = idle();  v.md_use_d = 1;
        repeat (DIV_N + 1) step(v);

        // $0 destination never stalls or forwards
        v = idle();  v.rw_e = 1;  v.a3_e = 0;  v.tnew_e = 2;  v.a1_d = 0;  v.tuse_rs = 0;
        v.rw_m = 1;  v.a3_m = 0;  v.rw_w = 1;  v.a3_w = 0;
        step(v);

        // Reset while the divider has six cycles to go; pending mfhi then proceeds
        v = idle();  v.md_op_e = 2'd2;
        step(v);
        v = idle();
        repeat (4) step(v);
        v = idle();  v.reset = 1;  v.md_use_d = 1;
        step(v);
        v = idle();  v.md_use_d = 1;
        step(v);

        // Unused rs (Tuse 3) ignores a matching long-latency producer
        v = idle();  v.a1_d = 5;  v.tuse_rs = 3;  v.rw_e = 1;  v.a3_e = 5;  v.tnew_e = 2;
        step(v);

        // Mult issue, then a reload while still busy
        v = idle();  v.md_op_e = 2'd1;
        step(v);
        v = idle();  v.md_use_d = 1;
        repeat (2) step(v);
        v = idle();  v.md_op_e = 2'd2;
        step(v);
        v = idle();  v.md_use_d = 1;
        repeat (DIV_N + 2) step(v);

        for (int i = 0; i < 2000; i++) step(rand_in());

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
